// File: rtl/io_stream_gearbox_pkg.sv
// Width and ratio helpers shared by the pad-side stream gearbox and its FIFOs.
// Used for elaboration-time parameter checks and counter sizing.
package io_stream_pkg;

    function automatic int ratio(input int wide, input int narrow);
        return wide / narrow;
    endfunction

    // Counters need at least one bit even when the ratio degenerates to 1.
    function automatic int cnt_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit divides(input int wide, input int narrow);
        return (narrow > 0) && (wide >= narrow) && ((wide % narrow) == 0);
    endfunction

endpackage

// File: rtl/io_stream_gearbox_stream_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers for full/empty detection.
// Read data comes straight from the array so a push is visible the next cycle.
module stream_fifo
    import io_stream_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [W-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data
);
    localparam int AW = cnt_w(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign push     = wr_valid && !full;
    assign pop      = rd_ready && !empty;
    assign rd_data  = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_stream_gearbox.sv
// Pad-side gearbox: packs narrow pad beats into IN_W words and unpacks OUT_W
// accelerator words into pad beats, with a FIFO in each direction.
module io_stream_gearbox
    import io_stream_pkg::*;
#(
    parameter int PAD_W = 8,
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             pad_in_valid,
    output logic             pad_in_ready,
    input  logic [PAD_W-1:0] pad_in_data,
    input  logic             pad_in_last,
    output logic             m_axis_valid,
    input  logic             m_axis_ready,
    output logic [IN_W-1:0]  m_axis_data,
    output logic             m_axis_last,
    input  logic             s_axis_valid,
    output logic             s_axis_ready,
    input  logic [OUT_W-1:0] s_axis_data,
    input  logic             s_axis_last,
    output logic             pad_out_valid,
    input  logic             pad_out_ready,
    output logic [PAD_W-1:0] pad_out_data,
    output logic             pad_out_last,
    output logic [15:0]      in_word_cnt,
    output logic [15:0]      out_word_cnt
);
    localparam int IN_R  = ratio(IN_W, PAD_W);
    localparam int OUT_R = ratio(OUT_W, PAD_W);
    localparam int LW    = cnt_w(IN_R);
    localparam int BW    = cnt_w(OUT_R);
    localparam logic [LW-1:0] LANE_LAST = LW'(IN_R - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(OUT_R - 1);

    if (!divides(IN_W, PAD_W)) begin : g_chk_in_w
        $error("IN_W must be an integer multiple of PAD_W");
    end
    if (!divides(OUT_W, PAD_W)) begin : g_chk_out_w
        $error("OUT_W must be an integer multiple of PAD_W");
    end
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_chk_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    // ---------------- pack path ----------------
    logic [LW-1:0]   lane_reg;
    logic [IN_W-1:0] asm_reg;
    logic [IN_W-1:0] pack_word;
    logic            in_fire;
    logic            in_push;
    logic            in_wr_ready;
    logic [15:0]     in_cnt_reg;

    // Current beat overlays its lane; already-filled lanes come from asm_reg.
    for (genvar gi = 0; gi < IN_R; gi++) begin : g_lane
        assign pack_word[gi*PAD_W +: PAD_W] =
            (lane_reg == LW'(gi)) ? pad_in_data : asm_reg[gi*PAD_W +: PAD_W];
    end

    assign pad_in_ready = in_wr_ready && !wb_rst_i;
    assign in_fire      = pad_in_valid && pad_in_ready;
    assign in_push      = in_fire && ((lane_reg == LANE_LAST) || pad_in_last);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            lane_reg   <= '0;
            asm_reg    <= '0;
            in_cnt_reg <= '0;
        end else if (in_fire) begin
            if (in_push) begin
                lane_reg   <= '0;
                asm_reg    <= '0;
                in_cnt_reg <= in_cnt_reg + 16'd1;
            end else begin
                lane_reg <= lane_reg + 1'b1;
                asm_reg  <= pack_word;
            end
        end
    end

    stream_fifo #(.W(IN_W + 1), .DEPTH(DEPTH)) u_in_fifo (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .wr_valid (in_push),
        .wr_ready (in_wr_ready),
        .wr_data  ({pad_in_last, pack_word}),
        .rd_valid (m_axis_valid),
        .rd_ready (m_axis_ready),
        .rd_data  ({m_axis_last, m_axis_data})
    );

    assign in_word_cnt = in_cnt_reg;

    // ---------------- unpack path ----------------
    logic             out_wr_ready;
    logic             out_rd_valid;
    logic [OUT_W:0]   out_rd_data;
    logic             out_pop;
    logic [OUT_W-1:0] sh_data_reg;
    logic             sh_last_reg;
    logic             sh_valid_reg;
    logic [BW-1:0]    beat_reg;
    logic [15:0]      out_cnt_reg;

    assign s_axis_ready = out_wr_ready && !wb_rst_i;

    stream_fifo #(.W(OUT_W + 1), .DEPTH(DEPTH)) u_out_fifo (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .wr_valid (s_axis_valid),
        .wr_ready (out_wr_ready),
        .wr_data  ({s_axis_last, s_axis_data}),
        .rd_valid (out_rd_valid),
        .rd_ready (out_pop),
        .rd_data  (out_rd_data)
    );

    // Reload while the last beat of the current word leaves, so words abut.
    assign out_pop = out_rd_valid &&
                     (!sh_valid_reg || (pad_out_ready && beat_reg == BEAT_LAST));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sh_data_reg  <= '0;
            sh_last_reg  <= 1'b0;
            sh_valid_reg <= 1'b0;
            beat_reg     <= '0;
        end else if (out_pop) begin
            sh_data_reg  <= out_rd_data[OUT_W-1:0];
            sh_last_reg  <= out_rd_data[OUT_W];
            sh_valid_reg <= 1'b1;
            beat_reg     <= '0;
        end else if (sh_valid_reg && pad_out_ready) begin
            if (beat_reg == BEAT_LAST) begin
                sh_valid_reg <= 1'b0;
            end else begin
                sh_data_reg <= sh_data_reg >> PAD_W;
                beat_reg    <= beat_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            out_cnt_reg <= '0;
        end else if (s_axis_valid && s_axis_ready) begin
            out_cnt_reg <= out_cnt_reg + 16'd1;
        end
    end

    assign pad_out_valid = sh_valid_reg;
    assign pad_out_data  = sh_data_reg[PAD_W-1:0];
    assign pad_out_last  = sh_last_reg && (beat_reg == BEAT_LAST);
    assign out_word_cnt  = out_cnt_reg;

endmodule

// File: tb/tb_io_stream_gearbox.sv
// Scoreboard bench for io_stream_gearbox: directed stimulus pushes expected
// words/beats into queues, negedge monitors pop and compare on each transfer.
module tb_io_stream_gearbox;
    localparam int PAD_W = 8;
    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             pad_in_valid;
    logic             pad_in_ready;
    logic [PAD_W-1:0] pad_in_data;
    logic             pad_in_last;
    logic             m_axis_valid;
    logic             m_axis_ready;
    logic [IN_W-1:0]  m_axis_data;
    logic             m_axis_last;
    logic             s_axis_valid;
    logic             s_axis_ready;
    logic [OUT_W-1:0] s_axis_data;
    logic             s_axis_last;
    logic             pad_out_valid;
    logic             pad_out_ready;
    logic [PAD_W-1:0] pad_out_data;
    logic             pad_out_last;
    logic [15:0]      in_word_cnt;
    logic [15:0]      out_word_cnt;

    int checks = 0;
    int passes = 0;
    int stall_cnt = 0;
    logic [IN_W:0]  exp_m [$];
    logic [PAD_W:0] exp_p [$];
    logic [IN_W:0]  m_e;
    logic [PAD_W:0] p_e;

    always #5 clk = ~clk;

    io_stream_gearbox #(.PAD_W(PAD_W), .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .pad_in_valid  (pad_in_valid),
        .pad_in_ready  (pad_in_ready),
        .pad_in_data   (pad_in_data),
        .pad_in_last   (pad_in_last),
        .m_axis_valid  (m_axis_valid),
        .m_axis_ready  (m_axis_ready),
        .m_axis_data   (m_axis_data),
        .m_axis_last   (m_axis_last),
        .s_axis_valid  (s_axis_valid),
        .s_axis_ready  (s_axis_ready),
        .s_axis_data   (s_axis_data),
        .s_axis_last   (s_axis_last),
        .pad_out_valid (pad_out_valid),
        .pad_out_ready (pad_out_ready),
        .pad_out_data  (pad_out_data),
        .pad_out_last  (pad_out_last),
        .in_word_cnt   (in_word_cnt),
        .out_word_cnt  (out_word_cnt)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && m_axis_valid && m_axis_ready) begin
            if (exp_m.size() == 0) begin
                checks++;
                $display("FAIL m_axis_unexpected: got 0x%0h last=%0b required no word", m_axis_data, m_axis_last);
            end else begin
                m_e = exp_m.pop_front();
                check("m_axis_word", {31'd0, m_axis_last, m_axis_data}, {31'd0, m_e});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && pad_out_valid && pad_out_ready) begin
            if (exp_p.size() == 0) begin
                checks++;
                $display("FAIL pad_out_unexpected: got 0x%0h last=%0b required no beat", pad_out_data, pad_out_last);
            end else begin
                p_e = exp_p.pop_front();
                check("pad_out_beat", {55'd0, pad_out_last, pad_out_data}, {55'd0, p_e});
            end
        end
    end

    task automatic send_beat(input logic [PAD_W-1:0] d, input logic l);
        int n = 0;
        bit rdy;
        pad_in_valid = 1'b1;
        pad_in_data  = d;
        pad_in_last  = l;
        forever begin
            @(negedge clk);
            rdy = pad_in_ready;
            if (!rdy) stall_cnt++;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 200) begin
                checks++;
                $display("FAIL pad_in_timeout: got ready=0 required accept within 200 cycles");
                break;
            end
        end
        pad_in_valid = 1'b0;
        pad_in_last  = 1'b0;
    endtask

    task automatic send_word(input logic [OUT_W-1:0] d, input logic l);
        int n = 0;
        bit rdy;
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        s_axis_last  = l;
        forever begin
            @(negedge clk);
            rdy = s_axis_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 200) begin
                checks++;
                $display("FAIL s_axis_timeout: got ready=0 required accept within 200 cycles");
                break;
            end
        end
        s_axis_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_m.size() != 0 || exp_p.size() != 0) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_m_queue", 64'(exp_m.size()), 64'd0);
        check("drain_p_queue", 64'(exp_p.size()), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        rst = 1'b1;
        pad_in_valid = 1'b0; pad_in_data = '0; pad_in_last = 1'b0;
        m_axis_ready = 1'b0; pad_out_ready = 1'b0;
        s_axis_valid = 1'b0; s_axis_data = '0; s_axis_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pad_in_ready", pad_in_ready, 0);
        check("rst_s_axis_ready", s_axis_ready, 0);
        check("rst_m_axis_valid", m_axis_valid, 0);
        check("rst_pad_out_valid", pad_out_valid, 0);
        check("rst_in_word_cnt", in_word_cnt, 0);
        check("rst_out_word_cnt", out_word_cnt, 0);
        rst = 1'b0;
        #1;
        check("rel_pad_in_ready", pad_in_ready, 1);
        check("rel_s_axis_ready", s_axis_ready, 1);
        m_axis_ready = 1'b1;
        pad_out_ready = 1'b1;

        // Full pack
        exp_m.push_back({1'b1, 32'h44332211});
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        check("pack_no_early_valid", m_axis_valid, 0);
        send_beat(8'h44, 1'b1);
        check("pack_latency_valid", m_axis_valid, 1);
        check("pack_in_word_cnt", in_word_cnt, 1);
        drain();

        // Early last
        exp_m.push_back({1'b1, 32'h0000BBAA});
        exp_m.push_back({1'b0, 32'h04030201});
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        for (int i = 1; i <= 4; i++) send_beat(8'(i), 1'b0);
        drain();
        check("early_in_word_cnt", in_word_cnt, 3);

        // Backpressure: 16 beats fill the FIFO, the 17th waits
        m_axis_ready = 1'b0;
        for (int w = 0; w < 5; w++)
            exp_m.push_back({1'b0, 8'(8'h23 + 4*w), 8'(8'h22 + 4*w), 8'(8'h21 + 4*w), 8'(8'h20 + 4*w)});
        for (int i = 0; i < 16; i++) send_beat(8'(8'h20 + i), 1'b0);
        check("bp_ready_low", pad_in_ready, 0);
        check("bp_in_word_cnt", in_word_cnt, 7);
        pad_in_valid = 1'b1; pad_in_data = 8'h30; pad_in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_ready_still_low", pad_in_ready, 0);
        check("bp_data_held", m_axis_data, 32'h23222120);
        m_axis_ready = 1'b1;
        for (int i = 16; i < 20; i++) send_beat(8'(8'h20 + i), 1'b0);
        drain();
        check("bp_in_word_cnt_end", in_word_cnt, 8);

        // Unpack two words back to back
        exp_p.push_back({1'b0, 8'h34});
        exp_p.push_back({1'b0, 8'h12});
        exp_p.push_back({1'b0, 8'hCD});
        exp_p.push_back({1'b1, 8'hAB});
        send_word(16'h1234, 1'b0);
        s_axis_valid = 1'b1; s_axis_data = 16'hABCD; s_axis_last = 1'b1;
        @(negedge clk);
        check("unpack_not_yet_valid", pad_out_valid, 0);
        check("unpack_second_ready", s_axis_ready, 1);
        @(posedge clk);
        #1;
        s_axis_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("unpack_contiguous_valid", pad_out_valid, 1);
        end
        drain();
        check("unpack_out_word_cnt", out_word_cnt, 2);

        // Reset mid-word with data pending in both directions
        m_axis_ready = 1'b0;
        pad_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(8'(8'hC0 + i), 1'b0);
        send_word(16'h5A5A, 1'b1);
        send_beat(8'h55, 1'b0);
        send_beat(8'h66, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_m_valid", m_axis_valid, 1);
        check("pre_rst_pad_out_valid", pad_out_valid, 1);
        rst = 1'b1;
        #1;
        check("midrst_m_valid", m_axis_valid, 0);
        check("midrst_pad_out_valid", pad_out_valid, 0);
        check("midrst_pad_in_ready", pad_in_ready, 0);
        check("midrst_in_word_cnt", in_word_cnt, 0);
        check("midrst_out_word_cnt", out_word_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        m_axis_ready = 1'b1;
        pad_out_ready = 1'b1;
        exp_m.push_back({1'b0, 32'h7A797877});
        for (int i = 0; i < 4; i++) send_beat(8'(8'h77 + i), 1'b0);
        drain();
        check("postrst_in_word_cnt", in_word_cnt, 1);

        // Streaming 64 beats at full rate
        stall_cnt = 0;
        for (int w = 0; w < 16; w++)
            exp_m.push_back({1'b0, 8'(4*w*3 + 10), 8'(4*w*3 + 7), 8'(4*w*3 + 4), 8'(4*w*3 + 1)});
        for (int i = 0; i < 64; i++) send_beat(8'(i*3 + 1), 1'b0);
        check("stream_no_stall", 64'(stall_cnt), 64'd0);
        drain();
        check("stream_in_word_cnt", in_word_cnt, 17);

        // Counter wrap: single-beat words until 65536 total pushes
        for (int i = 0; i < 65536 - 17; i++) begin
            b = 8'(i);
            exp_m.push_back({1'b1, 24'd0, b});
            send_beat(b, 1'b1);
        end
        drain();
        check("wrap_in_word_cnt", in_word_cnt, 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
